cook_timer_ctrl: RTL
====================

COOK_TIMER_CTRL -- requirements
Module: cook_timer_ctrl

Interface
REQ-001 SHALL have parameter ALARM_SEC, default 10, alarm auto-clear duration in clk_sec ticks (used only when COOK_TIMER_ALARM_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset_p  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port clk_sec  input  1  one-clk-cycle tick, once per second (from the second-divider stage).
REQ-005 SHALL have port btn_start  input  1  one-cycle pulse (edge-detected upstream); start/pause toggle.
REQ-006 SHALL have port btn_inc_min  input  1  one-cycle pulse; add one minute.
REQ-007 SHALL have port btn_inc_sec  input  1  one-cycle pulse; add one second.
REQ-008 SHALL have port btn_clear  input  1  one-cycle pulse; abort, zero the time.
REQ-009 SHALL have ports min10, min1, sec10, sec1  output  4 each  BCD mm:ss, registered.
REQ-010 SHALL have port running  output  1  high in RUN only.
REQ-011 SHALL have port alarm  output  1  high in ALARM only.
REQ-012 SHALL have port done_pulse  output  1  one-cycle pulse on the edge that enters ALARM.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE, ALARM; all outputs registered, one-cycle latency from input to output.
REQ-014 Input priority SHALL be btn_clear > btn_start > btn_inc_min/btn_inc_sec > clk_sec.
REQ-015 IDLE: btn_inc_sec SHALL add 1 s to the seconds field (59 -> 00, no carry into minutes); btn_inc_min SHALL add 1 min (99 -> 00); both in the same cycle SHALL apply both.
REQ-016 IDLE: btn_start with time != 00:00 SHALL go to RUN; with 00:00 SHALL stay in IDLE.
REQ-017 RUN: each clk_sec SHALL decrement mm:ss by one second in BCD (sec1 0 -> 9 borrows sec10; sec10 0 -> 5 borrows min1; min1 0 -> 9 borrows min10).
REQ-018 RUN: the clk_sec that takes the time from 00:01 to 00:00 SHALL enter ALARM on that edge, with done_pulse high for exactly that next cycle.
REQ-019 RUN: btn_start SHALL go to PAUSE; a clk_sec in the same cycle SHALL be dropped (no decrement).
REQ-020 RUN and PAUSE: btn_inc_min/btn_inc_sec SHALL be ignored.
REQ-021 PAUSE: time SHALL hold; btn_start SHALL return to RUN; clk_sec SHALL be ignored.
REQ-022 btn_clear in any state SHALL go to IDLE with time 00:00 and alarm 0.
REQ-023 ALARM: time SHALL hold 00:00; any of btn_start, btn_inc_min, btn_inc_sec, btn_clear SHALL go to IDLE; that press SHALL not modify the time.

Reset
REQ-024 reset_p SHALL, on the next clk edge and regardless of state, force IDLE, all digits 0, running=0, alarm=0, done_pulse=0, alarm timeout counter=0; reset_p overrides all other inputs.

Configuration
REQ-025 With COOK_TIMER_ALARM_TIMEOUT_EN defined, ALARM SHALL count clk_sec ticks and return to IDLE on the ALARM_SEC-th tick; the counter SHALL clear on ALARM entry.
REQ-026 Without COOK_TIMER_ALARM_TIMEOUT_EN, ALARM SHALL persist until a button press; no timeout counter SHALL be synthesised.

Structure
REQ-027 Shared package cook_timer_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, ALARM=2'd3) and BCD constants BCD_MAX_SEC10=5, BCD_MAX_DIG=9.
REQ-028 The mm:ss BCD arithmetic SHALL be a sub-module bcd_mmss_updown with load, inc_min, inc_sec, dec_tick inputs and a zero flag output; the FSM SHALL stay in cook_timer_ctrl.

Verification
REQ-029 Reset, 3x btn_inc_sec, 1x btn_inc_min -> 01:03, running=0.
REQ-030 Set 00:02, btn_start, 2 clk_sec -> 00:01, then 00:00 with alarm=1 and done_pulse high for one cycle.
REQ-031 Set 01:00, RUN, 1 clk_sec -> 00:59; btn_start with clk_sec in the same cycle -> PAUSE at 00:59; further clk_sec -> hold.
REQ-032 IDLE 00:00, btn_start -> stays IDLE; 60x btn_inc_sec -> 00:00 (wrap); 100x btn_inc_min -> 00:00.
REQ-033 With the macro defined (ALARM_SEC=10): ALARM plus 10 clk_sec -> IDLE; without the macro: ALARM plus 20 clk_sec -> still ALARM; btn_inc_sec -> IDLE at 00:00.
REQ-034 In RUN at 05:30, reset_p for one cycle -> IDLE 00:00 with all outputs 0 on the next edge.

Source files
------------

// File: rtl/cook_timer_pkg.sv
// Shared definitions for the cook timer: FSM state encoding, BCD digit limits
// and a wrapping BCD digit increment helper.
package cook_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX_SEC10 = 4'd5;
  localparam logic [3:0] BCD_MAX_DIG   = 4'd9;

  // Increment one BCD digit, wrapping to 0 after max_val.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] max_val);
    return (d >= max_val) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/cook_timer_ctrl_if.sv
// Command/status bundle between the cook timer FSM (master) and the mm:ss
// BCD counter (slave).
interface cook_timer_ctrl_if;
  logic       load;
  logic       inc_min;
  logic       inc_sec;
  logic       dec_tick;
  logic [3:0] min10;
  logic [3:0] min1;
  logic [3:0] sec10;
  logic [3:0] sec1;
  logic       zero;
  logic       one;

  modport master (
    output load, inc_min, inc_sec, dec_tick,
    input  min10, min1, sec10, sec1, zero, one
  );

  modport slave (
    input  load, inc_min, inc_sec, dec_tick,
    output min10, min1, sec10, sec1, zero, one
  );
endinterface

// File: rtl/cook_timer_ctrl_bcd_mmss_updown.sv
// Registered mm:ss BCD counter: load clears to 00:00, independent wrapping
// minute/second increments, and a one-second borrowing decrement.
module bcd_mmss_updown
  import cook_timer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_p,
  cook_timer_ctrl_if.slave  bus
);

  logic [3:0] min10_q, min1_q, sec10_q, sec1_q;
  logic [3:0] min10_d, min1_d, sec10_d, sec1_d;
  logic       zero_w;

  assign zero_w = (min10_q == 4'd0) && (min1_q == 4'd0) &&
                  (sec10_q == 4'd0) && (sec1_q == 4'd0);

  always_comb begin
    min10_d = min10_q;
    min1_d  = min1_q;
    sec10_d = sec10_q;
    sec1_d  = sec1_q;
    if (bus.load) begin
      min10_d = 4'd0;
      min1_d  = 4'd0;
      sec10_d = 4'd0;
      sec1_d  = 4'd0;
    end else if (bus.dec_tick && !zero_w) begin
      // Borrow ripples sec1 -> sec10 -> min1 -> min10.
      if (sec1_q != 4'd0) begin
        sec1_d = sec1_q - 4'd1;
      end else begin
        sec1_d = BCD_MAX_DIG;
        if (sec10_q != 4'd0) begin
          sec10_d = sec10_q - 4'd1;
        end else begin
          sec10_d = BCD_MAX_SEC10;
          if (min1_q != 4'd0) begin
            min1_d = min1_q - 4'd1;
          end else begin
            min1_d  = BCD_MAX_DIG;
            min10_d = min10_q - 4'd1;
          end
        end
      end
    end else begin
      // Seconds wrap 59 -> 00 without touching minutes.
      if (bus.inc_sec) begin
        sec1_d = bcd_inc(sec1_q, BCD_MAX_DIG);
        if (sec1_q >= BCD_MAX_DIG) sec10_d = bcd_inc(sec10_q, BCD_MAX_SEC10);
      end
      if (bus.inc_min) begin
        min1_d = bcd_inc(min1_q, BCD_MAX_DIG);
        if (min1_q >= BCD_MAX_DIG) min10_d = bcd_inc(min10_q, BCD_MAX_DIG);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      min10_q <= 4'd0;
      min1_q  <= 4'd0;
      sec10_q <= 4'd0;
      sec1_q  <= 4'd0;
    end else begin
      min10_q <= min10_d;
      min1_q  <= min1_d;
      sec10_q <= sec10_d;
      sec1_q  <= sec1_d;
    end
  end

  assign bus.min10 = min10_q;
  assign bus.min1  = min1_q;
  assign bus.sec10 = sec10_q;
  assign bus.sec1  = sec1_q;
  assign bus.zero  = zero_w;
  assign bus.one   = (min10_q == 4'd0) && (min1_q == 4'd0) &&
                     (sec10_q == 4'd0) && (sec1_q == 4'd1);

endmodule

// File: rtl/cook_timer_ctrl.sv
// Kitchen countdown timer FSM (IDLE/RUN/PAUSE/ALARM) driving a BCD mm:ss counter.
// Optional alarm auto-clear after ALARM_SEC seconds: COOK_TIMER_ALARM_TIMEOUT_EN.
module cook_timer_ctrl
  import cook_timer_pkg::*;
#(
  parameter int ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clk_sec,
  input  logic       btn_start,
  input  logic       btn_inc_min,
  input  logic       btn_inc_sec,
  input  logic       btn_clear,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       running,
  output logic       alarm,
  output logic       done_pulse
);

  cook_timer_ctrl_if bcd_bus ();

  bcd_mmss_updown u_bcd (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bcd_bus.slave)
  );

  state_e state_q, state_d;
  logic   running_q, alarm_q, done_q;
  logic   load_w, inc_min_w, inc_sec_w, dec_w;
  logic   any_btn_w, timeout_hit_w;

  assign any_btn_w = btn_start | btn_inc_min | btn_inc_sec | btn_clear;

`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
  localparam int CNT_W = $clog2(ALARM_SEC + 1);
  logic [CNT_W-1:0] alarm_cnt_q;

  assign timeout_hit_w = (state_q == ALARM) && clk_sec &&
                         (alarm_cnt_q == CNT_W'(ALARM_SEC - 1));

  // Held at zero outside ALARM, so every ALARM entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (reset_p || (state_q != ALARM)) begin
      alarm_cnt_q <= '0;
    end else if (clk_sec) begin
      alarm_cnt_q <= alarm_cnt_q + 1'b1;
    end
  end
`else
  logic unused_alarm_sec;
  assign unused_alarm_sec = (ALARM_SEC != 0);
  assign timeout_hit_w    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    load_w    = 1'b0;
    inc_min_w = 1'b0;
    inc_sec_w = 1'b0;
    dec_w     = 1'b0;
    if (btn_clear) begin
      state_d = IDLE;
      load_w  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_start) begin
            if (!bcd_bus.zero) state_d = RUN;
          end else begin
            inc_min_w = btn_inc_min;
            inc_sec_w = btn_inc_sec;
          end
        end
        RUN: begin
          // A pause press swallows a coincident second tick.
          if (btn_start) begin
            state_d = PAUSE;
          end else if (clk_sec) begin
            dec_w = 1'b1;
            if (bcd_bus.one) state_d = ALARM;
          end
        end
        PAUSE: begin
          if (btn_start) state_d = RUN;
        end
        ALARM: begin
          if (any_btn_w || timeout_hit_w) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bcd_bus.load     = load_w;
  assign bcd_bus.inc_min  = inc_min_w;
  assign bcd_bus.inc_sec  = inc_sec_w;
  assign bcd_bus.dec_tick = dec_w;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
      alarm_q   <= (state_d == ALARM);
      done_q    <= (state_q == RUN) && (state_d == ALARM);
    end
  end

  assign min10      = bcd_bus.min10;
  assign min1       = bcd_bus.min1;
  assign sec10      = bcd_bus.sec10;
  assign sec1       = bcd_bus.sec1;
  assign running    = running_q;
  assign alarm      = alarm_q;
  assign done_pulse = done_q;

endmodule
